// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch path.
// Holds the XLEN, the default reset PC and the in-flight fetch tag.
package imem_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } fetch_tag_t;

endpackage

// File: rtl/fetch_resp_fifo.sv
// Response buffer for fetched words: synchronous write, first-word-fall-through
// head, flush input; head data reads as zero while the buffer is empty.
module fetch_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_rdata = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_count;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop)
    );

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch initiator: PC generation, latency tag pipe, credit-based issue.
// Optional perf counters (fetch_cnt, bubble_cnt) under IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int READ_LATENCY = 2,
    localparam int FIFO_DEPTH = READ_LATENCY + 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_tag_t        r_tag [READ_LATENCY];
    logic [XLEN-1:0]   r_pc;
    logic [7:0]        w_pending;
    logic [7:0]        w_credit;
    logic              w_issue;
    logic              w_pop;
    logic              w_write;
    logic [CW-1:0]     w_count;
    logic [2*XLEN-1:0] w_head;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_pending = w_pending + {7'd0, r_tag[i].valid};
        end
    end

    // Buffered plus in-flight words must never exceed the buffer size
    assign w_pop    = instr_valid & instr_ready & ~redirect_valid;
    assign w_credit = 8'(w_count) + w_pending - {7'd0, w_pop};
    assign w_issue  = ~redirect_valid & (w_credit < 8'(FIFO_DEPTH));
    assign w_write  = r_tag[READ_LATENCY-1].valid & ~redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_issue) begin
            r_pc <= r_pc + XLEN'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else if (redirect_valid) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_issue;
            r_tag[0].pc    <= r_pc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    fetch_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_write),
        .i_wdata ({imem_rdata, r_tag[READ_LATENCY-1].pc}),
        .i_pop   (w_pop),
        .o_valid (instr_valid),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign imem_addr = r_pc;
    assign instr     = w_head[2*XLEN-1:XLEN];
    assign instr_pc  = w_head[XLEN-1:0];

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (instr_ready && !instr_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a latency-2 instruction memory model.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    logic [31:0] mem [16];
    logic [31:0] d1;
    int checks;
    int failures;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-edge read latency: address sampled, then data valid after the next edge
    always @(posedge clk) begin
        d1         <= mem[imem_addr[3:0]];
        imem_rdata <= d1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b want 0", instr_valid);
        end
        checks++;
        if (instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_instr: got %h want 0", instr);
        end
        checks++;
        if (instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc: got %h want 0", instr_pc);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr: got %h want 0", imem_addr);
        end
    endtask

    task automatic test_stream;
        apply_reset;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({instr_valid, imem_addr} !== {1'b0, 32'(c)}) begin
                failures++;
                $display("FAIL stream_fill c%0d: valid/addr %b/%h want 0/%h",
                         c, instr_valid, imem_addr, c);
            end
            tick;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(k), mem[k]}) begin
                failures++;
                $display("FAIL stream_out k%0d: got %b/%h/%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, k, mem[k]);
            end
            tick;
        end
`ifdef IMEM_FETCH_PERF_EN
        checks++;
        if (fetch_cnt !== 32'd4) begin
            failures++;
            $display("FAIL perf_fetch: got %0d want 4", fetch_cnt);
        end
        checks++;
        if (bubble_cnt !== 32'd3) begin
            failures++;
            $display("FAIL perf_bubble: got %0d want 3", bubble_cnt);
        end
`endif
    endtask

    task automatic test_backpressure;
        apply_reset;
        repeat (4) tick;
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({instr_valid, instr_pc, instr, imem_addr} !==
                {1'b1, 32'd1, mem[1], 32'd4}) begin
                failures++;
                $display("FAIL bp_hold i%0d: got %b/%h/%h addr %h want 1/1/%h addr 4",
                         i, instr_valid, instr_pc, instr, imem_addr, mem[1]);
            end
            tick;
        end
        instr_ready = 1'b1;
        checks++;
        if ({instr_valid, instr_pc, imem_addr} !== {1'b1, 32'd1, 32'd4}) begin
            failures++;
            $display("FAIL bp_release: got %b/%h addr %h want 1/1 addr 4",
                     instr_valid, instr_pc, imem_addr);
        end
        tick;
        for (int k = 2; k < 5; k++) begin
            checks++;
            if ({instr_valid, instr_pc, instr, imem_addr} !==
                {1'b1, 32'(k), mem[k], 32'(k + 3)}) begin
                failures++;
                $display("FAIL bp_drain k%0d: got %b/%h/%h addr %h want 1/%h/%h addr %h",
                         k, instr_valid, instr_pc, instr, imem_addr, k, mem[k], k + 3);
            end
            tick;
        end
    endtask

    task automatic test_redirect;
        apply_reset;
        repeat (4) tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL redir_flush: got %b addr %h want 0 addr 0",
                     instr_valid, imem_addr);
        end
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL redir_gap c%0d: got %b want 0", c, instr_valid);
            end
        end
        tick;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(k), mem[k]}) begin
                failures++;
                $display("FAIL redir_out k%0d: got %b/%h/%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, k, mem[k]);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        apply_reset;
        repeat (4) tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'd8;
        tick;
        checks++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'd8}) begin
            failures++;
            $display("FAIL b2b_first: got %b addr %h want 0 addr 8",
                     instr_valid, imem_addr);
        end
        redirect_pc = 32'd1;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'd1) begin
            failures++;
            $display("FAIL b2b_addr: got %h want 1", imem_addr);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gap c%0d: got %b/%h want 0", c, instr_valid, instr_pc);
            end
            tick;
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(k), mem[k]}) begin
                failures++;
                $display("FAIL b2b_out k%0d: got %b/%h/%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, k, mem[k]);
            end
            tick;
        end
    endtask

    task automatic test_wrap;
        apply_reset;
        repeat (4) tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_addr0: got %h want ffffffff", imem_addr);
        end
        tick;
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr1: got %h want 0", imem_addr);
        end
        tick;
        tick;
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hFFFF_FFFF, mem[15]}) begin
            failures++;
            $display("FAIL wrap_out0: got %b/%h/%h want 1/ffffffff/%h",
                     instr_valid, instr_pc, instr, mem[15]);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, mem[0]}) begin
            failures++;
            $display("FAIL wrap_out1: got %b/%h/%h want 1/0/%h",
                     instr_valid, instr_pc, instr, mem[0]);
        end
    endtask

    task automatic test_async_reset;
        apply_reset;
        repeat (5) tick;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({instr_valid, instr_pc, instr, imem_addr} !== {1'b0, 96'h0}) begin
            failures++;
            $display("FAIL async_rst: got %b/%h/%h addr %h want 0/0/0 addr 0",
                     instr_valid, instr_pc, instr, imem_addr);
        end
        tick;
        tick;
        rst = 1'b0;
        checks++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL async_rel: got %b addr %h want 0 addr 0",
                     instr_valid, imem_addr);
        end
        repeat (3) tick;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(k), mem[k]}) begin
                failures++;
                $display("FAIL async_out k%0d: got %b/%h/%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, k, mem[k]);
            end
            tick;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mem[0] = 32'h0000_1020;
        mem[1] = 32'h2022_0004;
        mem[2] = 32'h8C01_0001;
        mem[3] = 32'hAC01_0001;
        for (int i = 4; i < 16; i++) begin
            mem[i] = 32'hC0DE_0000 + 32'(i);
        end
        d1 = 32'h0;
        imem_rdata = 32'h0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;

        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_back_to_back;
        test_wrap;
        test_async_reset;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
